paddle_motion_ctrl: RTL and testbench

Frame-synchronous position controller for N independent paddles, the parametrised successor to the single-paddle mover. It sits between the debounced button inputs and the pixel renderer. Once per frame, on the falling edge of vsync, it moves every paddle by its current per-axis speed. Speed ramps up while a direction is held, moves that would leave the screen are clamped to the screen edge instead of being dropped, and edge contact is reported.

---
 rtl/paddle_pkg.sv | 30 +++
 rtl/paddle_axis.sv | 124 ++++++++++++
 rtl/paddle_motion_ctrl.sv | 88 ++++++++
 tb/tb_paddle_motion_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared types and defaults for the frame-synchronous paddle position controller.
package paddle_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_NEG  = 2'd1,
    DIR_POS  = 2'd2
  } dir_t;

  localparam int H_RES_DEF        = 1024;
  localparam int V_RES_DEF        = 768;
  localparam int PADDLE_W_DEF     = 300;
  localparam int PADDLE_H_DEF     = 300;
  localparam int INIT_X_DEF       = 400;
  localparam int INIT_Y_DEF       = 400;
  localparam int SPEED_MIN_DEF    = 1;
  localparam int SPEED_MAX_DEF    = 8;
  localparam int ACCEL_FRAMES_DEF = 4;
  localparam int SPEED_W          = $clog2(SPEED_MAX_DEF + 1);

  // Pressing both buttons of an axis cancels out, same as pressing neither.
  function automatic dir_t dir_decode(input logic neg, input logic pos);
    case ({neg, pos})
      2'b10:   return DIR_NEG;
      2'b01:   return DIR_POS;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// One axis of one paddle: speed ramp, edge clamp and hit pulse, evaluated on frame tick.
// Results register one cycle after the tick edge; no backpressure, state holds between ticks.
module paddle_axis
  import paddle_pkg::*;
#(
  parameter int W            = 11,
  parameter int RES          = H_RES_DEF,
  parameter int SIZE         = PADDLE_W_DEF,
  parameter int INIT         = INIT_X_DEF,
  parameter int SPEED_MIN    = SPEED_MIN_DEF,
  parameter int SPEED_MAX    = SPEED_MAX_DEF,
  parameter int ACCEL_FRAMES = ACCEL_FRAMES_DEF,
  parameter int SW           = SPEED_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_tick,
  input  logic         i_neg,
  input  logic         i_pos,
  output logic [W-1:0] o_min,
  output logic [W-1:0] o_max,
  output logic         o_hit
);

  localparam int HW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  localparam logic [W:0]    EDGE_HI   = (W+1)'(RES - 1);
  localparam logic [W-1:0]  MIN_HI    = W'(RES - 1 - SIZE);
  localparam logic [W-1:0]  SIZE_W    = W'(SIZE);
  localparam logic [W-1:0]  INIT_MIN  = W'(INIT);
  localparam logic [W-1:0]  INIT_MAX  = W'(INIT + SIZE);
  localparam logic [SW-1:0] SPD_MIN   = SW'(SPEED_MIN);
  localparam logic [SW-1:0] SPD_MAX   = SW'(SPEED_MAX);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ACCEL_FRAMES - 1);

  if ((INIT + SIZE > RES - 1) || (SPEED_MAX >= SIZE)) begin : g_cfg_err
    $error("paddle_axis: INIT+SIZE must fit on screen and SPEED_MAX must be below SIZE");
  end

  dir_t          r_dir_prev;
  logic [SW-1:0] r_speed;
  logic [HW-1:0] r_hold;
  logic [W-1:0]  r_min;
  logic [W-1:0]  r_max;
  logic          r_hit;

  dir_t          w_dir;
  logic [SW-1:0] w_speed_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic [W-1:0]  w_step;
  logic [W:0]    w_step_ext;
  logic [W:0]    w_min_ext;
  logic [W:0]    w_max_ext;
  logic [W-1:0]  w_min_nxt;
  logic          w_hit;

  always_comb begin
    w_dir       = dir_decode(i_neg, i_pos);
    w_speed_nxt = SPD_MIN;
    w_hold_nxt  = '0;
    // The frame that completes a hold period already moves at the raised speed.
    if (w_dir != DIR_NONE && w_dir == r_dir_prev) begin
      if (r_hold == HOLD_LAST) begin
        w_hold_nxt  = '0;
        w_speed_nxt = (r_speed >= SPD_MAX) ? SPD_MAX : r_speed + 1'b1;
      end else begin
        w_hold_nxt  = r_hold + 1'b1;
        w_speed_nxt = r_speed;
      end
    end

    w_step     = W'(w_speed_nxt);
    w_step_ext = {1'b0, w_step};
    w_min_ext  = {1'b0, r_min};
    w_max_ext  = {1'b0, r_max};
    w_min_nxt  = r_min;
    w_hit      = 1'b0;
    case (w_dir)
      DIR_NEG: begin
        if (w_min_ext < w_step_ext) begin
          w_min_nxt = '0;
          w_hit     = 1'b1;
        end else begin
          w_min_nxt = r_min - w_step;
        end
      end
      DIR_POS: begin
        if (w_max_ext + w_step_ext > EDGE_HI) begin
          w_min_nxt = MIN_HI;
          w_hit     = 1'b1;
        end else begin
          w_min_nxt = r_min + w_step;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dir_prev <= DIR_NONE;
      r_speed    <= SPD_MIN;
      r_hold     <= '0;
      r_min      <= INIT_MIN;
      r_max      <= INIT_MAX;
      r_hit      <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      if (i_tick) begin
        r_dir_prev <= w_dir;
        r_speed    <= w_speed_nxt;
        r_hold     <= w_hold_nxt;
        r_min      <= w_min_nxt;
        r_max      <= w_min_nxt + SIZE_W;
        r_hit      <= w_hit;
      end
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;
  assign o_hit = r_hit;

endmodule

// File: rtl/paddle_motion_ctrl.sv
// N-paddle frame-synchronous mover: vsync falling-edge detect feeding 2*N independent axes.
// Outputs update one cycle after the tick edge; no backpressure, buttons are sampled levels.
module paddle_motion_ctrl
  import paddle_pkg::*;
#(
  parameter int N_PADDLES    = 2,
  parameter int XW           = 11,
  parameter int YW           = 10,
  parameter int H_RES        = H_RES_DEF,
  parameter int V_RES        = V_RES_DEF,
  parameter int PADDLE_W     = PADDLE_W_DEF,
  parameter int PADDLE_H     = PADDLE_H_DEF,
  parameter int INIT_X       = INIT_X_DEF,
  parameter int INIT_Y       = INIT_Y_DEF,
  parameter int SPEED_MIN    = SPEED_MIN_DEF,
  parameter int SPEED_MAX    = SPEED_MAX_DEF,
  parameter int ACCEL_FRAMES = ACCEL_FRAMES_DEF
) (
  input  logic                    vclock,
  input  logic                    reset,
  input  logic                    vsync,
  input  logic [N_PADDLES-1:0]    up,
  input  logic [N_PADDLES-1:0]    down,
  input  logic [N_PADDLES-1:0]    left,
  input  logic [N_PADDLES-1:0]    right,
  output logic [N_PADDLES*XW-1:0] min_x,
  output logic [N_PADDLES*XW-1:0] max_x,
  output logic [N_PADDLES*YW-1:0] min_y,
  output logic [N_PADDLES*YW-1:0] max_y,
  output logic [N_PADDLES-1:0]    hit_x,
  output logic [N_PADDLES-1:0]    hit_y,
  output logic                    frame_tick
);

  localparam int SW = $clog2(SPEED_MAX + 1);

  logic r_last_vsync;
  logic r_frame_tick;
  logic w_tick;

  assign w_tick = r_last_vsync & ~vsync;

  // Capturing vsync during reset keeps a fall across reset release from ticking.
  always_ff @(posedge vclock) begin
    if (reset) begin
      r_last_vsync <= vsync;
      r_frame_tick <= 1'b0;
    end else begin
      r_last_vsync <= vsync;
      r_frame_tick <= w_tick;
    end
  end

  assign frame_tick = r_frame_tick;

  for (genvar i = 0; i < N_PADDLES; i++) begin : g_paddle
    paddle_axis #(
      .W(XW), .RES(H_RES), .SIZE(PADDLE_W), .INIT(INIT_X),
      .SPEED_MIN(SPEED_MIN), .SPEED_MAX(SPEED_MAX),
      .ACCEL_FRAMES(ACCEL_FRAMES), .SW(SW)
    ) u_axis_x (
      .clk    (vclock),
      .reset  (reset),
      .i_tick (w_tick),
      .i_neg  (left[i]),
      .i_pos  (right[i]),
      .o_min  (min_x[i*XW +: XW]),
      .o_max  (max_x[i*XW +: XW]),
      .o_hit  (hit_x[i])
    );

    paddle_axis #(
      .W(YW), .RES(V_RES), .SIZE(PADDLE_H), .INIT(INIT_Y),
      .SPEED_MIN(SPEED_MIN), .SPEED_MAX(SPEED_MAX),
      .ACCEL_FRAMES(ACCEL_FRAMES), .SW(SW)
    ) u_axis_y (
      .clk    (vclock),
      .reset  (reset),
      .i_tick (w_tick),
      .i_neg  (up[i]),
      .i_pos  (down[i]),
      .o_min  (min_y[i*YW +: YW]),
      .o_max  (max_y[i*YW +: YW]),
      .o_hit  (hit_y[i])
    );
  end

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Directed bench for paddle_motion_ctrl: reset, ramp, clamps, reversal, held vsync, mid-ramp reset.
module tb_paddle_motion_ctrl;

  localparam int N  = 2;
  localparam int XW = 11;
  localparam int YW = 10;

  logic            vclock = 1'b0;
  logic            reset  = 1'b1;
  logic            vsync  = 1'b1;
  logic [N-1:0]    up     = '0;
  logic [N-1:0]    down   = '0;
  logic [N-1:0]    left   = '0;
  logic [N-1:0]    right  = '0;
  logic [N*XW-1:0] min_x, max_x;
  logic [N*YW-1:0] min_y, max_y;
  logic [N-1:0]    hit_x, hit_y;
  logic            frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 vclock = ~vclock;

  paddle_motion_ctrl #(
    .N_PADDLES(N), .XW(XW), .YW(YW), .H_RES(1024), .V_RES(768),
    .PADDLE_W(300), .PADDLE_H(300), .INIT_X(400), .INIT_Y(400),
    .SPEED_MIN(1), .SPEED_MAX(8), .ACCEL_FRAMES(4)
  ) dut (
    .vclock(vclock), .reset(reset), .vsync(vsync),
    .up(up), .down(down), .left(left), .right(right),
    .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
    .hit_x(hit_x), .hit_y(hit_y), .frame_tick(frame_tick)
  );

  task automatic do_reset();
    reset = 1'b1;
    up = '0; down = '0; left = '0; right = '0;
    vsync = 1'b1;
    repeat (2) @(posedge vclock);
    #1 vsync = 1'b0;
    @(posedge vclock);
    #1 reset = 1'b0;
  endtask

  // Raise vsync for one cycle then drop it; returns #1 after the tick edge.
  task automatic do_frame();
    vsync = 1'b1;
    @(posedge vclock);
    #1 vsync = 1'b0;
    @(posedge vclock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    up = '0; down = '0; left = '0; right = '0;
    vsync = 1'b1;
    repeat (3) @(posedge vclock);
    #1 vsync = 1'b0;
    @(posedge vclock);
    #1 reset = 1'b0;
    n_tests++;
    if (min_x !== {11'd400, 11'd400}) begin
      n_fail++; $display("FAIL reset_min_x: got %h want %h", min_x, {11'd400, 11'd400});
    end
    n_tests++;
    if (max_x !== {11'd700, 11'd700}) begin
      n_fail++; $display("FAIL reset_max_x: got %h want %h", max_x, {11'd700, 11'd700});
    end
    n_tests++;
    if (min_y !== {10'd400, 10'd400}) begin
      n_fail++; $display("FAIL reset_min_y: got %h want %h", min_y, {10'd400, 10'd400});
    end
    n_tests++;
    if (max_y !== {10'd700, 10'd700}) begin
      n_fail++; $display("FAIL reset_max_y: got %h want %h", max_y, {10'd700, 10'd700});
    end
    n_tests++;
    if (hit_x !== 2'b00 || hit_y !== 2'b00 || frame_tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: got hx=%b hy=%b ft=%b want 00 00 0", hit_x, hit_y, frame_tick);
    end
    @(posedge vclock);
    #1;
    n_tests++;
    if (frame_tick !== 1'b0 || min_x !== {11'd400, 11'd400}) begin
      n_fail++; $display("FAIL reset_first_cycle_tick: got ft=%b min_x=%h want 0 and unchanged", frame_tick, min_x);
    end
  endtask

  task automatic test_ramp();
    int steps [9] = '{1, 1, 1, 1, 2, 2, 2, 2, 3};
    int ex = 400;
    do_reset();
    right[0] = 1'b1;
    for (int f = 0; f < 9; f++) begin
      do_frame();
      ex += steps[f];
      n_tests++;
      if (int'(min_x[10:0]) != ex || int'(max_x[10:0]) != ex + 300 || frame_tick !== 1'b1 || hit_x !== 2'b00) begin
        n_fail++;
        $display("FAIL ramp_frame%0d: got min=%0d max=%0d ft=%b hit=%b want min=%0d max=%0d ft=1 hit=00",
                 f, min_x[10:0], max_x[10:0], frame_tick, hit_x, ex, ex + 300);
      end
    end
    n_tests++;
    if (min_x[21:11] !== 11'd400 || min_y !== {10'd400, 10'd400}) begin
      n_fail++; $display("FAIL ramp_other_unchanged: got p1x=%0d min_y=%h want 400", min_x[21:11], min_y);
    end
    @(posedge vclock);
    #1;
    n_tests++;
    if (frame_tick !== 1'b0 || min_x[10:0] !== 11'd415) begin
      n_fail++; $display("FAIL ramp_tick_width: got ft=%b min=%0d want 0 415", frame_tick, min_x[10:0]);
    end
    right = '0;
  endtask

  task automatic test_clamp_neg();
    do_reset();
    up[0] = 1'b1;
    repeat (70) do_frame();
    n_tests++;
    if (min_y[9:0] !== 10'd0 || max_y[9:0] !== 10'd300) begin
      n_fail++; $display("FAIL clamp_top_reach: got min=%0d max=%0d want 0 300", min_y[9:0], max_y[9:0]);
    end
    up = '0; do_frame();
    down[0] = 1'b1; repeat (8) do_frame();
    down = '0; do_frame();
    down[0] = 1'b1; repeat (2) do_frame();
    down = '0; do_frame();
    n_tests++;
    if (min_y[9:0] !== 10'd14) begin
      n_fail++; $display("FAIL clamp_setup14: got %0d want 14", min_y[9:0]);
    end
    up[0] = 1'b1;
    repeat (8) do_frame();
    n_tests++;
    if (min_y[9:0] !== 10'd2 || hit_y !== 2'b00) begin
      n_fail++; $display("FAIL clamp_setup2: got min=%0d hit=%b want 2 00", min_y[9:0], hit_y);
    end
    do_frame();
    n_tests++;
    if (min_y[9:0] !== 10'd0 || max_y[9:0] !== 10'd300 || hit_y !== 2'b01) begin
      n_fail++; $display("FAIL clamp_neg_hit: got min=%0d max=%0d hit=%b want 0 300 01", min_y[9:0], max_y[9:0], hit_y);
    end
    @(posedge vclock);
    #1;
    n_tests++;
    if (hit_y !== 2'b00) begin
      n_fail++; $display("FAIL clamp_hit_width: got %b want 00", hit_y);
    end
    do_frame();
    n_tests++;
    if (min_y[9:0] !== 10'd0 || hit_y !== 2'b01) begin
      n_fail++; $display("FAIL clamp_push_at_edge: got min=%0d hit=%b want 0 01", min_y[9:0], hit_y);
    end
    up = '0;
  endtask

  task automatic test_clamp_pos();
    do_reset();
    right[0] = 1'b1;
    repeat (100) do_frame();
    n_tests++;
    if (min_x[10:0] !== 11'd723 || max_x[10:0] !== 11'd1023 || hit_x !== 2'b01) begin
      n_fail++; $display("FAIL clamp_right_edge: got min=%0d max=%0d hit=%b want 723 1023 01", min_x[10:0], max_x[10:0], hit_x);
    end
    n_tests++;
    if (min_y[9:0] !== 10'd400 || min_x[21:11] !== 11'd400) begin
      n_fail++; $display("FAIL clamp_right_indep: got y=%0d p1x=%0d want 400 400", min_y[9:0], min_x[21:11]);
    end
    right = '0;
  endtask

  task automatic test_reversal();
    do_reset();
    right[0] = 1'b1;
    repeat (9) do_frame();
    n_tests++;
    if (min_x[10:0] !== 11'd415) begin
      n_fail++; $display("FAIL rev_setup: got %0d want 415", min_x[10:0]);
    end
    right = '0; left[0] = 1'b1;
    do_frame();
    n_tests++;
    if (min_x[10:0] !== 11'd414) begin
      n_fail++; $display("FAIL rev_first_move: got %0d want 414", min_x[10:0]);
    end
    do_frame();
    n_tests++;
    if (min_x[10:0] !== 11'd413) begin
      n_fail++; $display("FAIL rev_speed_reset: got %0d want 413", min_x[10:0]);
    end
    right[0] = 1'b1;
    do_frame();
    n_tests++;
    if (min_x[10:0] !== 11'd413 || hit_x !== 2'b00) begin
      n_fail++; $display("FAIL rev_conflict: got min=%0d hit=%b want 413 00", min_x[10:0], hit_x);
    end
    left = '0;
    do_frame();
    n_tests++;
    if (min_x[10:0] !== 11'd414) begin
      n_fail++; $display("FAIL rev_after_conflict: got %0d want 414", min_x[10:0]);
    end
    right = '0;
  endtask

  task automatic test_vsync_low();
    int ticks = 0;
    do_reset();
    down[0] = 1'b1;
    vsync = 1'b1;
    @(posedge vclock);
    #1 vsync = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge vclock);
      #1;
      if (frame_tick === 1'b1) ticks++;
    end
    n_tests++;
    if (ticks != 1 || min_y[9:0] !== 10'd401) begin
      n_fail++; $display("FAIL vsync_low_single: got ticks=%0d min_y=%0d want 1 401", ticks, min_y[9:0]);
    end
    down = '0;
  endtask

  task automatic test_midramp_reset();
    do_reset();
    right[0] = 1'b1;
    repeat (17) do_frame();
    n_tests++;
    if (min_x[10:0] !== 11'd445) begin
      n_fail++; $display("FAIL midramp_setup: got %0d want 445", min_x[10:0]);
    end
    reset = 1'b1;
    vsync = 1'b1;
    @(posedge vclock);
    #1;
    n_tests++;
    if (min_x !== {11'd400, 11'd400} || max_x !== {11'd700, 11'd700} || frame_tick !== 1'b0 || hit_x !== 2'b00) begin
      n_fail++; $display("FAIL midramp_reset_vals: got min=%h max=%h ft=%b want 400/700 ft=0", min_x, max_x, frame_tick);
    end
    vsync = 1'b0;
    @(posedge vclock);
    #1;
    n_tests++;
    if (frame_tick !== 1'b0 || min_x[10:0] !== 11'd400) begin
      n_fail++; $display("FAIL reset_beats_tick: got ft=%b min=%0d want 0 400", frame_tick, min_x[10:0]);
    end
    reset = 1'b0;
    do_frame();
    n_tests++;
    if (min_x[10:0] !== 11'd401) begin
      n_fail++; $display("FAIL midramp_restart: got %0d want 401", min_x[10:0]);
    end
    right = '0;
  endtask

  task automatic test_independent();
    do_reset();
    down[0] = 1'b1; left[1] = 1'b1; up[1] = 1'b1;
    do_frame();
    n_tests++;
    if (min_x !== {11'd399, 11'd400} || max_x !== {11'd699, 11'd700}) begin
      n_fail++; $display("FAIL indep_x: got min=%h max=%h want %h %h", min_x, max_x, {11'd399, 11'd400}, {11'd699, 11'd700});
    end
    n_tests++;
    if (min_y !== {10'd399, 10'd401} || max_y !== {10'd699, 10'd701}) begin
      n_fail++; $display("FAIL indep_y: got min=%h max=%h want %h %h", min_y, max_y, {10'd399, 10'd401}, {10'd699, 10'd701});
    end
    up = '0; down = '0; left = '0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_clamp_neg();
    test_clamp_pos();
    test_reversal();
    test_vsync_low();
    test_midramp_reset();
    test_independent();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
